eceg_seq_ctrl: RTL and testbench

Sequential controller for the ECEG cryptosystem, successor to the combinational keygen/encrypt/decrypt chain. It computes the public key Y = s·P once per key load, then runs one Elgamal round trip per message: C1 = k·P, C2 = M + k·Y, and optionally M' = C2 − s·C1 with a compare. It sits between a message source and one shared multi-cycle point multiplier and one point adder, which it drives over start/done handshakes.

---
 rtl/eceg_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_eceg_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eceg_seq_ctrl.sv
// rtl/eceg_seq_ctrl.sv - sequential ECEG keygen / Elgamal encrypt / decrypt-check controller
//
// Computes Y = s*P once per key load, then per message C1 = k*P, C2 = M + k*Y and,
// when ECEG_DECRYPT_CHECK_EN is defined, M' = C2 - s*C1 with out_match = (M' == M).
// Drives one shared point multiplier and one point adder over start/done handshakes.
//
// Optional feature macro: ECEG_DECRYPT_CHECK_EN (decrypt round trip, compare, fail counting)
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   key_load, key_s                pulse to latch secret scalar and run keygen
//   px, py                         static base point P
//   msg_valid/msg_ready            message handshake (msg_x, msg_y, msg_k)
//   out_valid/out_ready            result handshake (c1x, c1y, c2x, c2y, out_match)
//   key_ready, yx, yy              public key valid / public key
//   pass_cnt, fail_cnt             saturating round-trip counters
//   mul_*                          point multiplier request/response
//   add_*                          point adder request/response (add_sub=1: A-B)
module eceg_seq_ctrl #(
    parameter int DATAWIDTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_load,
    input  logic [DATAWIDTH-1:0] key_s,
    input  logic [DATAWIDTH-1:0] px,
    input  logic [DATAWIDTH-1:0] py,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [DATAWIDTH-1:0] msg_x,
    input  logic [DATAWIDTH-1:0] msg_y,
    input  logic [DATAWIDTH-1:0] msg_k,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] c1x,
    output logic [DATAWIDTH-1:0] c1y,
    output logic [DATAWIDTH-1:0] c2x,
    output logic [DATAWIDTH-1:0] c2y,
    output logic                 out_match,
    output logic                 key_ready,
    output logic [DATAWIDTH-1:0] yx,
    output logic [DATAWIDTH-1:0] yy,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 mul_start,
    output logic [DATAWIDTH-1:0] mul_n,
    output logic [DATAWIDTH-1:0] mul_qx,
    output logic [DATAWIDTH-1:0] mul_qy,
    input  logic                 mul_done,
    input  logic [DATAWIDTH-1:0] mul_rx,
    input  logic [DATAWIDTH-1:0] mul_ry,
    output logic                 add_start,
    output logic                 add_sub,
    output logic [DATAWIDTH-1:0] add_ax,
    output logic [DATAWIDTH-1:0] add_ay,
    output logic [DATAWIDTH-1:0] add_bx,
    output logic [DATAWIDTH-1:0] add_by,
    input  logic                 add_done,
    input  logic [DATAWIDTH-1:0] add_rx,
    input  logic [DATAWIDTH-1:0] add_ry
);

    typedef enum logic [3:0] {
        IDLE, KEYGEN, WAIT_MSG, ENC_C1, ENC_KY, ENC_ADD, DEC_SC1, DEC_SUB, RESULT
    } state_t;

    state_t state, state_nx;

    // Set once the start pulse of the current operation state has been issued;
    // done is only honoured while this is set, so a done coincident with start
    // (or a stale done from an aborted engine) never advances the FSM.
    logic op_busy;

    logic [DATAWIDTH-1:0] s_q, mx_q, my_q, k_q, tx_q, ty_q, ux_q, uy_q;
    logic is_mul_op, is_add_op, mul_fire, add_fire, msg_acc, key_acc;

    assign is_mul_op = (state == KEYGEN) || (state == ENC_C1) ||
                       (state == ENC_KY) || (state == DEC_SC1);
    assign is_add_op = (state == ENC_ADD) || (state == DEC_SUB);
    assign mul_start = is_mul_op && !op_busy;
    assign add_start = is_add_op && !op_busy;
    assign mul_fire  = is_mul_op && op_busy && mul_done;
    assign add_fire  = is_add_op && op_busy && add_done;
    assign msg_ready = (state == WAIT_MSG);
    assign out_valid = (state == RESULT);
    assign msg_acc   = msg_ready && msg_valid;
    // A message accepted in the same cycle wins over a re-key request.
    assign key_acc   = key_load && ((state == IDLE) || ((state == WAIT_MSG) && !msg_valid));

    // Engine operands come straight from registers selected by state, so they
    // stay constant from start until done.
    always_comb begin
        mul_n   = '0;
        mul_qx  = '0;
        mul_qy  = '0;
        add_sub = 1'b0;
        add_ax  = '0;
        add_ay  = '0;
        add_bx  = '0;
        add_by  = '0;
        case (state)
            KEYGEN: begin
                mul_n  = s_q;
                mul_qx = px;
                mul_qy = py;
            end
            ENC_C1: begin
                mul_n  = k_q;
                mul_qx = px;
                mul_qy = py;
            end
            ENC_KY: begin
                mul_n  = k_q;
                mul_qx = yx;
                mul_qy = yy;
            end
            DEC_SC1: begin
                mul_n  = s_q;
                mul_qx = c1x;
                mul_qy = c1y;
            end
            ENC_ADD: begin
                add_ax = mx_q;
                add_ay = my_q;
                add_bx = tx_q;
                add_by = ty_q;
            end
            DEC_SUB: begin
                add_sub = 1'b1;
                add_ax  = c2x;
                add_ay  = c2y;
                add_bx  = ux_q;
                add_by  = uy_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (key_acc) state_nx = KEYGEN;
            KEYGEN:   if (mul_fire) state_nx = WAIT_MSG;
            WAIT_MSG: begin
                if (msg_acc)      state_nx = ENC_C1;
                else if (key_acc) state_nx = KEYGEN;
            end
            ENC_C1:   if (mul_fire) state_nx = ENC_KY;
            ENC_KY:   if (mul_fire) state_nx = ENC_ADD;
`ifdef ECEG_DECRYPT_CHECK_EN
            ENC_ADD:  if (add_fire) state_nx = DEC_SC1;
            DEC_SC1:  if (mul_fire) state_nx = DEC_SUB;
            DEC_SUB:  if (add_fire) state_nx = RESULT;
`else
            ENC_ADD:  if (add_fire) state_nx = RESULT;
`endif
            RESULT:   if (out_ready) state_nx = WAIT_MSG;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_busy   <= 1'b0;
            s_q       <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            k_q       <= '0;
            tx_q      <= '0;
            ty_q      <= '0;
            ux_q      <= '0;
            uy_q      <= '0;
            yx        <= '0;
            yy        <= '0;
            key_ready <= 1'b0;
            c1x       <= '0;
            c1y       <= '0;
            c2x       <= '0;
            c2y       <= '0;
            pass_cnt  <= '0;
        end else begin
            if (mul_start || add_start) begin
                op_busy <= 1'b1;
            end else if (mul_fire || add_fire) begin
                op_busy <= 1'b0;
            end

            if (key_acc) begin
                s_q       <= key_s;
                key_ready <= 1'b0;
            end

            if (msg_acc) begin
                mx_q <= msg_x;
                my_q <= msg_y;
                k_q  <= msg_k;
            end

            if (mul_fire) begin
                case (state)
                    KEYGEN: begin
                        yx        <= mul_rx;
                        yy        <= mul_ry;
                        key_ready <= 1'b1;
                    end
                    ENC_C1: begin
                        c1x <= mul_rx;
                        c1y <= mul_ry;
                    end
                    ENC_KY: begin
                        tx_q <= mul_rx;
                        ty_q <= mul_ry;
                    end
                    DEC_SC1: begin
                        ux_q <= mul_rx;
                        uy_q <= mul_ry;
                    end
                    default: ;
                endcase
            end

            if (add_fire && (state == ENC_ADD)) begin
                c2x <= add_rx;
                c2y <= add_ry;
            end

`ifdef ECEG_DECRYPT_CHECK_EN
            if (out_valid && out_ready && out_match && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
`else
            if (out_valid && out_ready && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
`endif
        end
    end

`ifdef ECEG_DECRYPT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_match <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            if (add_fire && (state == DEC_SUB)) begin
                out_match <= (add_rx == mx_q) && (add_ry == my_q);
            end
            if (out_valid && out_ready && !out_match && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign out_match = 1'b1;
    assign fail_cnt  = '0;
`endif

endmodule

// File: tb/tb_eceg_seq_ctrl.sv
// tb/tb_eceg_seq_ctrl.sv - randomized self-checking bench for eceg_seq_ctrl
`timescale 1ns/1ps
module tb_eceg_seq_ctrl;

    localparam int DW = 16;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef ECEG_DECRYPT_CHECK_EN
    localparam bit DEC_EN = 1'b1;
    localparam int NOPS   = 5;
`else
    localparam bit DEC_EN = 1'b0;
    localparam int NOPS   = 3;
`endif
    localparam logic [DW-1:0] PX = 16'h1234;
    localparam logic [DW-1:0] PY = 16'h0567;

    logic clk, rst_n, key_load, msg_valid, msg_ready, out_valid, out_ready;
    logic [DW-1:0] key_s, px, py, msg_x, msg_y, msg_k;
    logic [DW-1:0] c1x, c1y, c2x, c2y, yx, yy;
    logic out_match, key_ready;
    logic [CW-1:0] pass_cnt, fail_cnt;
    logic mul_start, mul_done, add_start, add_sub, add_done;
    logic [DW-1:0] mul_n, mul_qx, mul_qy, mul_rx, mul_ry;
    logic [DW-1:0] add_ax, add_ay, add_bx, add_by, add_rx, add_ry;

    int n_checks = 0;
    int n_fail   = 0;

    eceg_seq_ctrl #(.DATAWIDTH(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_s(key_s),
        .px(px), .py(py), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_x(msg_x), .msg_y(msg_y), .msg_k(msg_k),
        .out_valid(out_valid), .out_ready(out_ready),
        .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y), .out_match(out_match),
        .key_ready(key_ready), .yx(yx), .yy(yy),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .mul_start(mul_start), .mul_n(mul_n), .mul_qx(mul_qx), .mul_qy(mul_qy),
        .mul_done(mul_done), .mul_rx(mul_rx), .mul_ry(mul_ry),
        .add_start(add_start), .add_sub(add_sub), .add_ax(add_ax), .add_ay(add_ay),
        .add_bx(add_bx), .add_by(add_by), .add_done(add_done),
        .add_rx(add_rx), .add_ry(add_ry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mock engines work in the additive group Z_2^16 x Z_2^16: n*Q scales each
    // coordinate, so C2 - s*C1 recovers M exactly like on a real curve.
    int  lat_sum = 0;
    int  mul_starts = 0;
    int  add_starts = 0;
    bit  corrupt_sub = 1'b0;
    bit  add_sub_seen = 1'b0;
    bit  mul_busy, add_busy;
    int  mul_rem, add_rem;
    logic [DW-1:0] cm_n, cm_qx, cm_qy, ca_ax, ca_ay, ca_bx, ca_by;
    logic ca_sub;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_busy = 1'b0; mul_done = 1'b0; mul_rem = 0; mul_rx = '0; mul_ry = '0;
        end else begin
            mul_done = 1'b0;
            if (mul_busy) begin
                mul_rem--;
                if (mul_rem == 0) begin
                    check("mul_operands_stable", {mul_n, mul_qx, mul_qy}, {cm_n, cm_qx, cm_qy});
                    mul_done = 1'b1;
                    mul_rx = cm_n * cm_qx;
                    mul_ry = cm_n * cm_qy;
                    mul_busy = 1'b0;
                end
            end
            if (mul_start) begin
                cm_n = mul_n; cm_qx = mul_qx; cm_qy = mul_qy;
                mul_busy = 1'b1;
                mul_rem = $urandom_range(1, 4);
                lat_sum += mul_rem;
                mul_starts++;
                if ($urandom_range(0, 1) == 1) begin
                    mul_done = 1'b1; mul_rx = 16'hdead; mul_ry = 16'hbeef;
                end
            end
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_busy = 1'b0; add_done = 1'b0; add_rem = 0; add_rx = '0; add_ry = '0;
        end else begin
            add_done = 1'b0;
            if (add_busy) begin
                add_rem--;
                if (add_rem == 0) begin
                    check("add_operands_stable", {add_sub, add_ax, add_ay, add_bx, add_by},
                          {ca_sub, ca_ax, ca_ay, ca_bx, ca_by});
                    add_done = 1'b1;
                    add_rx = ca_sub ? ca_ax - ca_bx : ca_ax + ca_bx;
                    add_ry = ca_sub ? ca_ay - ca_by : ca_ay + ca_by;
                    if (ca_sub && corrupt_sub) add_rx = add_rx + 16'd1;
                    add_busy = 1'b0;
                end
            end
            if (add_start) begin
                ca_sub = add_sub; ca_ax = add_ax; ca_ay = add_ay; ca_bx = add_bx; ca_by = add_by;
                if (add_sub) add_sub_seen = 1'b1;
                add_busy = 1'b1;
                add_rem = $urandom_range(1, 4);
                lat_sum += add_rem;
                add_starts++;
                if ($urandom_range(0, 1) == 1) begin
                    add_done = 1'b1; add_rx = 16'h5a5a; add_ry = 16'ha5a5;
                end
            end
        end
    end

    // Reference model state
    logic [DW-1:0] m_s;
    int m_pass = 0;
    int m_fail = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_msg_ready();
        int n = 0;
        while (!msg_ready && n < 200) begin
            tick();
            n++;
        end
        check("msg_ready_timeout", msg_ready, 1'b1);
    endtask

    task automatic do_keyload(input logic [DW-1:0] s);
        int st0, n;
        logic [DW-1:0] ex, ey;
        st0 = mul_starts;
        key_s = s;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        check("key_ready_drop", key_ready, 1'b0);
        n = 0;
        while (!key_ready && n < 100) begin
            tick();
            n++;
        end
        check("key_timeout", key_ready, 1'b1);
        m_s = s;
        ex = s * PX;
        ey = s * PY;
        check("yx", yx, ex);
        check("yy", yy, ey);
        check("keygen_msg_ready", msg_ready, 1'b1);
        check("keygen_mul_starts", mul_starts - st0, 1);
    endtask

    task automatic send_msg(input logic [DW-1:0] mx, input logic [DW-1:0] my,
                            input logic [DW-1:0] k, input bit corrupt,
                            input int hold, input bit kl);
        int cnt, st0;
        logic [DW-1:0] yex, yey, e_c1x, e_c1y, e_c2x, e_c2y, mpx, mpy;
        logic e_match;
        logic [64:0] snap;
        wait_msg_ready();
        corrupt_sub = corrupt;
        msg_x = mx; msg_y = my; msg_k = k;
        msg_valid = 1'b1;
        lat_sum = 0;
        tick();
        msg_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 300) begin
            key_load = kl && (cnt == 1);
            if (kl && cnt == 1) key_s = DW'($urandom);
            tick();
            cnt++;
        end
        key_load = 1'b0;
        check("result_timeout", out_valid, 1'b1);
        check("latency", cnt, lat_sum + NOPS + 1);

        yex = m_s * PX;  yey = m_s * PY;
        e_c1x = k * PX;  e_c1y = k * PY;
        e_c2x = mx + k * yex;
        e_c2y = my + k * yey;
        mpx = e_c2x - m_s * e_c1x + (corrupt ? 16'd1 : 16'd0);
        mpy = e_c2y - m_s * e_c1y;
        e_match = DEC_EN ? ((mpx == mx) && (mpy == my)) : 1'b1;
        check("c1x", c1x, e_c1x);
        check("c1y", c1y, e_c1y);
        check("c2x", c2x, e_c2x);
        check("c2y", c2y, e_c2y);
        check("out_match", out_match, e_match);
        check("yx_kept", {yx, yy}, {yex, yey});
        check("result_msg_ready", msg_ready, 1'b0);

        if (hold > 0) begin
            snap = {c1x, c1y, c2x, c2y, out_match};
            st0 = mul_starts + add_starts;
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", {c1x, c1y, c2x, c2y, out_match}, snap);
                check("hold_msg_ready", msg_ready, 1'b0);
            end
            check("hold_no_start", mul_starts + add_starts - st0, 0);
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (e_match) m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
        else         m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
        check("pass_cnt", pass_cnt, m_pass);
        check("fail_cnt", fail_cnt, m_fail);
        check("valid_dropped", out_valid, 1'b0);
        corrupt_sub = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, |{msg_ready, out_valid, c1x, c1y, c2x, c2y, key_ready, yx, yy,
                     pass_cnt, fail_cnt, mul_start, mul_n, mul_qx, mul_qy,
                     add_start, add_sub, add_ax, add_ay, add_bx, add_by}, 1'b0);
        check({tag, "_match"}, out_match, !DEC_EN);
    endtask

    initial begin
        int st0, n;
        rst_n = 1'b0; key_load = 1'b0; key_s = '0; px = PX; py = PY;
        msg_valid = 1'b0; msg_x = '0; msg_y = '0; msg_k = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        st0 = mul_starts + add_starts;
        repeat (5) tick();
        check("idle_no_start", mul_starts + add_starts - st0, 0);
        check("idle_key_ready", key_ready, 1'b0);
        check("idle_msg_ready", msg_ready, 1'b0);

        do_keyload(16'd7);
        send_msg(16'h0011, 16'h0022, 16'd5, 1'b0, 0, 1'b0);
        send_msg(DW'($urandom), DW'($urandom), DW'($urandom), 1'b1, 0, 1'b0);
        send_msg(DW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 10, 1'b0);
        send_msg(DW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 0, 1'b1);
        do_keyload(DW'($urandom));
        check("rekey_pass_kept", pass_cnt, m_pass);
        for (int i = 0; i < 4; i++) begin
            send_msg(DW'($urandom), DW'($urandom), DW'($urandom), 1'b0,
                     $urandom_range(0, 3), 1'b0);
        end

        // Reset while the ENC_KY multiply is in flight.
        wait_msg_ready();
        msg_x = DW'($urandom); msg_y = DW'($urandom); msg_k = DW'($urandom);
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        st0 = mul_starts;
        n = 0;
        while ((mul_starts - st0) < 2 && n < 100) begin
            tick();
            n++;
        end
        check("reach_enc_ky", (mul_starts - st0) >= 2, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midop_reset_outputs");
        tick();
        tick();
        rst_n = 1'b1;
        m_pass = 0;
        m_fail = 0;
        st0 = mul_starts + add_starts;
        repeat (8) tick();
        check("post_reset_no_start", mul_starts + add_starts - st0, 0);
        check("post_reset_key_ready", key_ready, 1'b0);
        check("post_reset_msg_ready", msg_ready, 1'b0);

        do_keyload(DW'($urandom));
        send_msg(DW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 2, 1'b0);
        check("sub_seen", add_sub_seen, DEC_EN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

endmodule
